// File: rtl/bpm_capture_bram_writer_pkg.sv
// ---------------------------------------------------------------------------
// bpm_capture_bram_writer_pkg
// Purpose : Shared definitions for the BPM capture BRAM writer: the capture
//           state encoding and a small helper that turns a word index into a
//           byte offset on the 32-bit BRAM port.
// Contents: capState_t enum (IDLE, CLEAR, PRE, POST, DONE), BYTES_PER_WORD_LOG2,
//           wordByteOffset().
// ---------------------------------------------------------------------------
package bpm_capture_bram_writer_pkg;

  // Capture sequence: clear the whole buffer, run circularly until a trigger,
  // write the post-trigger tail, then hold the result for software.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_PRE   = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } capState_t;

  // The BRAM port is byte addressed with one 32-bit word per location.
  localparam int BYTES_PER_WORD_LOG2 = 2;

  // Word index to byte offset.
  function automatic logic [31:0] wordByteOffset(input logic [31:0] wordIdx);
    return wordIdx << BYTES_PER_WORD_LOG2;
  endfunction

endpackage

// File: rtl/bpm_capture_bram_writer_if.sv
// ---------------------------------------------------------------------------
// bpm_capture_bram_writer_if
// Purpose : The port-B side of the MicroBlaze dual-port data BRAM.
// Signals : BRAM_EN    port enable
//           BRAM_WEN   byte write enables
//           BRAM_Addr  byte address
//           BRAM_Dout  write data toward memory
//           BRAM_Din   read data from memory
// Modports: master = initiator (the capture writer), slave = the memory.
// ---------------------------------------------------------------------------
interface bpm_capture_bram_writer_if #(
  parameter int C_PORT_DWIDTH = 32,
  parameter int C_PORT_AWIDTH = 32,
  parameter int C_NUM_WE      = 4
);

  logic                     BRAM_EN;
  logic [0:C_NUM_WE-1]      BRAM_WEN;
  logic [0:C_PORT_AWIDTH-1] BRAM_Addr;
  logic [0:C_PORT_DWIDTH-1] BRAM_Dout;
  logic [0:C_PORT_DWIDTH-1] BRAM_Din;

  modport master (
    output BRAM_EN,
    output BRAM_WEN,
    output BRAM_Addr,
    output BRAM_Dout,
    input  BRAM_Din
  );

  modport slave (
    input  BRAM_EN,
    input  BRAM_WEN,
    input  BRAM_Addr,
    input  BRAM_Dout,
    output BRAM_Din
  );

endinterface

// File: rtl/bpm_capture_addr_gen.sv
// ---------------------------------------------------------------------------
// bpm_capture_addr_gen
// Purpose : Circular word pointer for the capture buffer, the "wrapped" flag
//           and formation of the BRAM byte address for the current word.
// Ports   : clk, rst      clock, async active-high reset
//           i_clr         pointer to 0 and wrapped flag cleared (wins over i_inc)
//           i_inc         advance pointer by one word, modulo the buffer depth
//           i_wrapEn      allow an increment from the last word to set o_wrapped
//           o_ptr         current word index
//           o_wrapped     sticky wrap flag
//           o_byteAddr    C_BASEADDR + byte offset of o_ptr
// ---------------------------------------------------------------------------
module bpm_capture_addr_gen
  import bpm_capture_bram_writer_pkg::*;
#(
  parameter int                     C_DEPTH_LOG2  = 12,
  parameter int                     C_PORT_AWIDTH = 32,
  parameter logic [C_PORT_AWIDTH-1:0] C_BASEADDR  = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clr,
  input  logic                     i_inc,
  input  logic                     i_wrapEn,
  output logic [C_DEPTH_LOG2-1:0]  o_ptr,
  output logic                     o_wrapped,
  output logic [C_PORT_AWIDTH-1:0] o_byteAddr
);

  localparam logic [C_DEPTH_LOG2-1:0] PTR_MAX = '1;

  logic [C_DEPTH_LOG2-1:0] r_ptr;
  logic                    r_wrapped;

  // The pointer simply rolls over at the top of the buffer; the wrap flag
  // only records the rollover when the caller says it matters (pre-trigger
  // filling), so the initial clear pass never marks the buffer as wrapped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr     <= '0;
      r_wrapped <= 1'b0;
    end else if (i_clr) begin
      r_ptr     <= '0;
      r_wrapped <= 1'b0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + 1'b1;
      if (i_wrapEn && (r_ptr == PTR_MAX)) begin
        r_wrapped <= 1'b1;
      end
    end
  end

  assign o_ptr      = r_ptr;
  assign o_wrapped  = r_wrapped;
  assign o_byteAddr = C_BASEADDR + C_PORT_AWIDTH'(wordByteOffset(32'(r_ptr)));

endmodule

// File: rtl/bpm_capture_bram_writer.sv
// ---------------------------------------------------------------------------
// bpm_capture_bram_writer
// Purpose : Owns port B of the MicroBlaze data BRAM and writes a triggered
//           circular capture of the BPM sample stream. On Arm it clears the
//           buffer, fills it circularly until Trig, writes Post_Count more
//           samples and then reports Done with the trigger and last pointers
//           so software can unwrap the record through port A.
// Ports   : BRAM_Clk, BRAM_Rst   clock, async active-high reset
//           Arm / Abort / Trig   1-cycle control pulses
//           Post_Count           post-trigger sample count, latched on Arm
//           Smp_Valid / Smp_Data sample stream
//           bram                 BRAM port (master modport), all registered
//           Busy, Done, Wrapped  status
//           Trig_Addr, Last_Addr word indices of trigger and final sample
//           Drop_Cnt             samples lost while clearing (saturating)
// ---------------------------------------------------------------------------
module bpm_capture_bram_writer
  import bpm_capture_bram_writer_pkg::*;
#(
  parameter int                       C_PORT_DWIDTH = 32,
  parameter int                       C_PORT_AWIDTH = 32,
  parameter int                       C_NUM_WE      = 4,
  parameter int                       C_DEPTH_LOG2  = 12,
  parameter logic [C_PORT_AWIDTH-1:0] C_BASEADDR    = '0
) (
  input  logic                     BRAM_Clk,
  input  logic                     BRAM_Rst,
  input  logic                     Arm,
  input  logic                     Abort,
  input  logic                     Trig,
  input  logic [C_DEPTH_LOG2-1:0]  Post_Count,
  input  logic                     Smp_Valid,
  input  logic [C_PORT_DWIDTH-1:0] Smp_Data,
  bpm_capture_bram_writer_if.master bram,
  output logic                     Busy,
  output logic                     Done,
  output logic                     Wrapped,
  output logic [C_DEPTH_LOG2-1:0]  Trig_Addr,
  output logic [C_DEPTH_LOG2-1:0]  Last_Addr,
  output logic [15:0]              Drop_Cnt
);

  localparam logic [C_DEPTH_LOG2-1:0] PTR_MAX = '1;
  localparam logic [C_DEPTH_LOG2-1:0] REM_ONE = C_DEPTH_LOG2'(1);
  localparam logic [C_NUM_WE-1:0]     WEN_ALL = '1;

  capState_t r_state;
  capState_t w_nextState;

  logic [C_DEPTH_LOG2-1:0]  r_postCount;
  logic [C_DEPTH_LOG2-1:0]  r_rem;
  logic [C_DEPTH_LOG2-1:0]  r_trigAddr;
  logic [C_DEPTH_LOG2-1:0]  r_lastAddr;
  logic [15:0]              r_dropCnt;

  logic                     r_en;
  logic [C_NUM_WE-1:0]      r_wen;
  logic [C_PORT_AWIDTH-1:0] r_addr;
  logic [C_PORT_DWIDTH-1:0] r_dout;

  logic                     w_write;
  logic [C_PORT_DWIDTH-1:0] w_wrData;
  logic                     w_ptrInc;
  logic                     w_wrapEn;
  logic                     w_armAccept;
  logic                     w_setTrig;
  logic                     w_setLast;
  logic [C_DEPTH_LOG2-1:0]  w_lastVal;
  logic                     w_loadRem;
  logic                     w_decRem;
  logic                     w_drop;

  logic [C_DEPTH_LOG2-1:0]  w_ptr;
  logic                     w_wrapped;
  logic [C_PORT_AWIDTH-1:0] w_byteAddr;
  logic                     w_unusedDin;

  // Word pointer, wrap flag and byte address live in their own block; an
  // accepted Arm restarts the pointer at word 0 for the clear pass, and the
  // clear pass itself rolls the pointer back to 0 ready for capture.
  bpm_capture_addr_gen #(
    .C_DEPTH_LOG2  (C_DEPTH_LOG2),
    .C_PORT_AWIDTH (C_PORT_AWIDTH),
    .C_BASEADDR    (C_BASEADDR)
  ) u_addrGen (
    .clk        (BRAM_Clk),
    .rst        (BRAM_Rst),
    .i_clr      (w_armAccept),
    .i_inc      (w_ptrInc),
    .i_wrapEn   (w_wrapEn),
    .o_ptr      (w_ptr),
    .o_wrapped  (w_wrapped),
    .o_byteAddr (w_byteAddr)
  );

  // State register for the capture sequence.
  always_ff @(posedge BRAM_Clk or posedge BRAM_Rst) begin
    if (BRAM_Rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and per-cycle actions. The trigger pointer is the current
  // pointer whether or not a sample arrives with the trigger, because a
  // same-cycle sample is written exactly there. With a zero post count the
  // record ends on the trigger cycle: on its sample if there was one, else on
  // the word before the pointer. Abort overrides everything, including Arm,
  // and suppresses any new write; a write already in the port register still
  // goes out.
  always_comb begin
    w_nextState = r_state;
    w_write     = 1'b0;
    w_wrData    = Smp_Data;
    w_ptrInc    = 1'b0;
    w_wrapEn    = 1'b0;
    w_armAccept = 1'b0;
    w_setTrig   = 1'b0;
    w_setLast   = 1'b0;
    w_lastVal   = w_ptr;
    w_loadRem   = 1'b0;
    w_decRem    = 1'b0;
    w_drop      = 1'b0;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (Arm) begin
          w_armAccept = 1'b1;
          w_nextState = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        w_write  = 1'b1;
        w_wrData = '0;
        w_ptrInc = 1'b1;
        w_drop   = Smp_Valid;
        if (w_ptr == PTR_MAX) begin
          w_nextState = ST_PRE;
        end
      end
      ST_PRE: begin
        if (Smp_Valid) begin
          w_write  = 1'b1;
          w_ptrInc = 1'b1;
          w_wrapEn = 1'b1;
        end
        if (Trig) begin
          w_setTrig = 1'b1;
          w_loadRem = 1'b1;
          if (r_postCount == '0) begin
            w_setLast   = 1'b1;
            w_lastVal   = Smp_Valid ? w_ptr : (w_ptr - 1'b1);
            w_nextState = ST_DONE;
          end else begin
            w_nextState = ST_POST;
          end
        end
      end
      ST_POST: begin
        if (Smp_Valid) begin
          w_write  = 1'b1;
          w_ptrInc = 1'b1;
          w_decRem = 1'b1;
          if (r_rem == REM_ONE) begin
            w_setLast   = 1'b1;
            w_lastVal   = w_ptr;
            w_nextState = ST_DONE;
          end
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase

    if (Abort) begin
      w_nextState = ST_IDLE;
      w_write     = 1'b0;
      w_ptrInc    = 1'b0;
      w_wrapEn    = 1'b0;
      w_armAccept = 1'b0;
      w_setTrig   = 1'b0;
      w_setLast   = 1'b0;
      w_loadRem   = 1'b0;
      w_decRem    = 1'b0;
      w_drop      = 1'b0;
    end
  end

  // Capture bookkeeping: latched post count, remaining post samples, the
  // two result pointers and the drop counter. Post_Count is only as wide as
  // a word index, so it can never exceed DEPTH-1 and is latched unchanged.
  always_ff @(posedge BRAM_Clk or posedge BRAM_Rst) begin
    if (BRAM_Rst) begin
      r_postCount <= '0;
      r_rem       <= '0;
      r_trigAddr  <= '0;
      r_lastAddr  <= '0;
      r_dropCnt   <= '0;
    end else begin
      if (w_armAccept) begin
        r_postCount <= Post_Count;
        r_trigAddr  <= '0;
        r_lastAddr  <= '0;
        r_dropCnt   <= '0;
      end
      if (w_loadRem) begin
        r_rem <= r_postCount;
      end else if (w_decRem) begin
        r_rem <= r_rem - 1'b1;
      end
      if (w_setTrig) begin
        r_trigAddr <= w_ptr;
      end
      if (w_setLast) begin
        r_lastAddr <= w_lastVal;
      end
      if (w_drop && (r_dropCnt != 16'hFFFF)) begin
        r_dropCnt <= r_dropCnt + 16'd1;
      end
    end
  end

  // Registered BRAM port: each write decided this cycle is presented on the
  // port next cycle. Address and data simply hold between writes; only the
  // enables need to drop back to zero.
  always_ff @(posedge BRAM_Clk or posedge BRAM_Rst) begin
    if (BRAM_Rst) begin
      r_en   <= 1'b0;
      r_wen  <= '0;
      r_addr <= '0;
      r_dout <= '0;
    end else begin
      r_en  <= w_write;
      r_wen <= w_write ? WEN_ALL : '0;
      if (w_write) begin
        r_addr <= w_byteAddr;
        r_dout <= w_wrData;
      end
    end
  end

  assign bram.BRAM_EN   = r_en;
  assign bram.BRAM_WEN  = r_wen;
  assign bram.BRAM_Addr = r_addr;
  assign bram.BRAM_Dout = r_dout;

  // Port B never reads; the read bus is folded away on purpose.
  assign w_unusedDin = ^bram.BRAM_Din;

  assign Busy      = (r_state == ST_CLEAR) || (r_state == ST_PRE) || (r_state == ST_POST);
  assign Done      = (r_state == ST_DONE);
  assign Wrapped   = w_wrapped;
  assign Trig_Addr = r_trigAddr;
  assign Last_Addr = r_lastAddr;
  assign Drop_Cnt  = r_dropCnt;

endmodule

// File: tb/tb_bpm_capture_bram_writer.sv
// ---------------------------------------------------------------------------
// tb_bpm_capture_bram_writer
// Purpose : Self-checking bench for bpm_capture_bram_writer with a 16-word
//           buffer at base address 0. Every expected BRAM write is queued
//           when the stimulus that causes it is driven; a monitor pops and
//           compares each write as it appears on the port.
// ---------------------------------------------------------------------------
module tb_bpm_capture_bram_writer;

  localparam int DL    = 4;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wrExp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic          trig = 1'b0;
  logic [DL-1:0] postCount = '0;
  logic          smpValid = 1'b0;
  logic [31:0]   smpData = '0;
  logic          busy;
  logic          done;
  logic          wrapped;
  logic [DL-1:0] trigAddr;
  logic [DL-1:0] lastAddr;
  logic [15:0]   dropCnt;

  wrExp_t expQ[$];
  wrExp_t monExp;
  int     testsRun = 0;
  int     testsFailed = 0;
  int     mdlPtr = 0;

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  bpm_capture_bram_writer_if #(
    .C_PORT_DWIDTH (32),
    .C_PORT_AWIDTH (32),
    .C_NUM_WE      (4)
  ) bramIf ();

  assign bramIf.BRAM_Din = '0;

  bpm_capture_bram_writer #(
    .C_PORT_DWIDTH (32),
    .C_PORT_AWIDTH (32),
    .C_NUM_WE      (4),
    .C_DEPTH_LOG2  (DL),
    .C_BASEADDR    (32'h0)
  ) dut (
    .BRAM_Clk   (clk),
    .BRAM_Rst   (rst),
    .Arm        (arm),
    .Abort      (abort),
    .Trig       (trig),
    .Post_Count (postCount),
    .Smp_Valid  (smpValid),
    .Smp_Data   (smpData),
    .bram       (bramIf),
    .Busy       (busy),
    .Done       (done),
    .Wrapped    (wrapped),
    .Trig_Addr  (trigAddr),
    .Last_Addr  (lastAddr),
    .Drop_Cnt   (dropCnt)
  );

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle of stimulus. When a write is expected from it, the
  // write is queued at the bench's own circular pointer.
  task automatic applyStimulus(input logic valid, input logic [31:0] data, input logic trg,
                               input logic armIn, input logic abortIn, input bit expWrite);
    smpValid = valid;
    smpData  = data;
    trig     = trg;
    arm      = armIn;
    abort    = abortIn;
    if (expWrite) begin
      expQ.push_back('{addr: 32'(mdlPtr * 4), data: data});
      mdlPtr = (mdlPtr + 1) % DEPTH;
    end
    @(posedge clk);
    #1;
    smpValid = 1'b0;
    trig     = 1'b0;
    arm      = 1'b0;
    abort    = 1'b0;
  endtask

  // Arm, then run through the 16-cycle clear pass; the first dropN clear
  // cycles carry a sample that must be dropped.
  task automatic armCapture(input logic [DL-1:0] pc, input int dropN);
    for (int i = 0; i < DEPTH; i++) begin
      expQ.push_back('{addr: 32'(i * 4), data: 32'h0});
    end
    mdlPtr    = 0;
    postCount = pc;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(i < dropN, 32'hDEAD0000 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic checkDrained(input string tag);
    @(posedge clk);
    #1;
    checkOutput(tag, 32'(expQ.size()), 32'd0);
  endtask

  // Port monitor, sampled on the falling edge away from the active edge.
  always @(negedge clk) begin
    if (!rst && bramIf.BRAM_EN) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedWrite", bramIf.BRAM_Addr, 32'hFFFFFFFF);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("wrAddr", bramIf.BRAM_Addr, monExp.addr);
        checkOutput("wrData", bramIf.BRAM_Dout, monExp.data);
        checkOutput("wrWen", 32'(bramIf.BRAM_WEN), 32'hF);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstEn", 32'(bramIf.BRAM_EN), 32'd0);
    checkOutput("rstWrapped", 32'(wrapped), 32'd0);
    checkOutput("rstDrop", 32'(dropCnt), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Clear pass then basic capture: A0..A4 with trigger on A4, B0..B2 after.
    armCapture(4'd3, 0);
    checkOutput("clearBusy", 32'(busy), 32'd1);
    checkOutput("clearDone", 32'(done), 32'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 32'hA0 + 32'(i), i == 4, 1'b0, 1'b0, 1'b1);
    end
    checkOutput("basicBusyPost", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'hB0 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b1);
    end
    checkOutput("basicDone", 32'(done), 32'd1);
    checkOutput("basicBusy", 32'(busy), 32'd0);
    checkOutput("basicTrigAddr", 32'(trigAddr), 32'd4);
    checkOutput("basicLastAddr", 32'(lastAddr), 32'd7);
    checkOutput("basicWrapped", 32'(wrapped), 32'd0);
    applyStimulus(1'b1, 32'hEE, 1'b0, 1'b0, 1'b0, 1'b0);
    checkDrained("basicDrained");

    // Re-arm from DONE and wrap: 20 pre samples, trigger on the 20th, 2 post.
    armCapture(4'd2, 0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 32'hC00 + 32'(i), i == 19, 1'b0, 1'b0, 1'b1);
    end
    applyStimulus(1'b1, 32'hD0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'hD1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("wrapDone", 32'(done), 32'd1);
    checkOutput("wrapWrapped", 32'(wrapped), 32'd1);
    checkOutput("wrapTrigAddr", 32'(trigAddr), 32'd3);
    checkOutput("wrapLastAddr", 32'(lastAddr), 32'd5);
    checkDrained("wrapDrained");

    // Arm and Abort together in DONE: Abort wins, no clear pass.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("armAbortBusy", 32'(busy), 32'd0);
    checkOutput("armAbortDone", 32'(done), 32'd0);
    checkDrained("armAbortDrained");

    // Post_Count = 0 with a sample-less trigger: Done one cycle later.
    armCapture(4'd0, 0);
    applyStimulus(1'b1, 32'h51, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h52, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("pc0DoneBefore", 32'(done), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("pc0Done", 32'(done), 32'd1);
    checkOutput("pc0TrigAddr", 32'(trigAddr), 32'd2);
    checkOutput("pc0LastAddr", 32'(lastAddr), 32'd1);
    checkDrained("pc0Drained");

    // Post_Count = 15: exactly 15 post writes, extra samples ignored.
    armCapture(4'hF, 0);
    applyStimulus(1'b1, 32'h600, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b1, 32'h601 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b1);
    end
    checkOutput("pcMaxDoneEarly", 32'(done), 32'd0);
    applyStimulus(1'b1, 32'h60F, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("pcMaxDone", 32'(done), 32'd1);
    checkOutput("pcMaxTrigAddr", 32'(trigAddr), 32'd0);
    checkOutput("pcMaxLastAddr", 32'(lastAddr), 32'd15);
    applyStimulus(1'b1, 32'h6AA, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h6BB, 1'b0, 1'b0, 1'b0, 1'b0);
    checkDrained("pcMaxDrained");

    // Abuse: samples during clear are counted, Arm in PRE ignored, Abort in POST.
    armCapture(4'd5, 5);
    checkOutput("dropCnt", 32'(dropCnt), 32'd5);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("armInPreBusy", 32'(busy), 32'd1);
    checkOutput("armInPreDrop", 32'(dropCnt), 32'd5);
    applyStimulus(1'b1, 32'h91, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h92, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h93, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("abortBusy", 32'(busy), 32'd0);
    checkOutput("abortDone", 32'(done), 32'd0);
    applyStimulus(1'b1, 32'h94, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("abortDoneLater", 32'(done), 32'd0);
    checkDrained("abortDrained");

    // Reset asserted mid-POST, right as a write sits on the port.
    armCapture(4'd3, 0);
    applyStimulus(1'b1, 32'h71, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h72, 1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("midRstEn", 32'(bramIf.BRAM_EN), 32'd0);
    checkOutput("midRstWen", 32'(bramIf.BRAM_WEN), 32'd0);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    checkOutput("midRstDone", 32'(done), 32'd0);
    checkOutput("midRstTrigAddr", 32'(trigAddr), 32'd0);
    expQ.delete();
    mdlPtr = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    armCapture(4'd1, 0);
    checkOutput("postRstBusy", 32'(busy), 32'd1);
    applyStimulus(1'b1, 32'h81, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h82, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("postRstDone", 32'(done), 32'd1);
    checkOutput("postRstLastAddr", 32'(lastAddr), 32'd1);
    checkDrained("postRstDrained");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
